// File: rtl/receptor_uart.sv
// receptor_uart: UART receiver, 8N1 by default; define RECEPTOR_PARIDAD_EN for start+8+even parity+stop
module receptor_uart #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dato,
  output logic       dato_listo,
  output logic       error_trama,
  output logic       error_paridad,
  output logic       ocupado
);
  localparam int CICLOS_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CICLOS_BIT);
  localparam logic [CW-1:0] FIN_BIT = CW'(CICLOS_BIT - 1);
  localparam logic [CW-1:0] MITAD = CW'(CICLOS_BIT / 2 - 1);
`ifdef RECEPTOR_PARIDAD_EN
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARIDAD, PARADA, ESPERA} estado_t;
`else
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARADA, ESPERA} estado_t;
`endif
  estado_t estado, estado_d;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] n_bit, n_bit_d;
  logic [7:0] sr, sr_d, dato_d;
  logic listo_d, trama_d;
`ifdef RECEPTOR_PARIDAD_EN
  logic par_err, par_err_d, paridad_d;
`endif
  assign ocupado = estado != REPOSO;
  // two-stage synchronizer; idles high so reset does not fake a start bit
  always_ff @(posedge clk) {rx_s, rx_m} <= rst ? 2'b11 : {rx_m, rx};
  // state, counters, shift register and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOSO;
      cnt <= '0;
      n_bit <= '0;
      sr <= '0;
      dato <= '0;
      dato_listo <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      estado <= estado_d;
      cnt <= cnt_d;
      n_bit <= n_bit_d;
      sr <= sr_d;
      dato <= dato_d;
      dato_listo <= listo_d;
      error_trama <= trama_d;
    end
  end
`ifdef RECEPTOR_PARIDAD_EN
  // parity verdict is held from the parity bit until the stop bit resolves the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
      error_paridad <= 1'b0;
    end else begin
      par_err <= par_err_d;
      error_paridad <= paridad_d;
    end
  end
`else
  assign error_paridad = 1'b0;
`endif
  // next-state: mid-bit sampling driven by a per-bit cycle counter
  always_comb begin
    estado_d = estado;
    cnt_d = cnt + 1'b1;
    n_bit_d = n_bit;
    sr_d = sr;
    dato_d = dato;
    listo_d = 1'b0;
    trama_d = 1'b0;
`ifdef RECEPTOR_PARIDAD_EN
    par_err_d = par_err;
    paridad_d = 1'b0;
`endif
    case (estado)
      REPOSO: begin
        cnt_d = '0;
        if (!rx_s) estado_d = INICIO;
      end
      INICIO: if (cnt == MITAD) begin
        cnt_d = '0;
        n_bit_d = '0;
        estado_d = rx_s ? REPOSO : DATOS;
      end
      DATOS: if (cnt == FIN_BIT) begin
        cnt_d = '0;
        sr_d = {rx_s, sr[7:1]};
        n_bit_d = n_bit + 1'b1;
`ifdef RECEPTOR_PARIDAD_EN
        if (n_bit == 3'd7) estado_d = PARIDAD;
`else
        if (n_bit == 3'd7) estado_d = PARADA;
`endif
      end
`ifdef RECEPTOR_PARIDAD_EN
      PARIDAD: if (cnt == FIN_BIT) begin
        cnt_d = '0;
        par_err_d = rx_s ^ (^sr);
        estado_d = PARADA;
      end
`endif
      PARADA: if (cnt == FIN_BIT) begin
        cnt_d = '0;
        estado_d = rx_s ? REPOSO : ESPERA;
        trama_d = !rx_s;
`ifdef RECEPTOR_PARIDAD_EN
        paridad_d = rx_s && par_err;
        listo_d = rx_s && !par_err;
`else
        listo_d = rx_s;
`endif
        dato_d = listo_d ? sr : dato;
      end
      ESPERA: if (rx_s) estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end
endmodule
